gelu_requant: RTL and testbench

Stream sink for the integer GELU pipeline. Accepts 32-bit GELU results and requantizes each with a dyadic scale (multiply, round, arithmetic shift). Saturates each result to signed 8-bit, packs four lanes per 32-bit word, and presents the words on a valid/ready master port through a small FIFO. It drives the upstream pipeline's `enable` so that a stalled consumer freezes GELU instead of dropping data.

---
 rtl/gelu_requant_if.sv | 33 +++
 rtl/gelu_requant.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_gelu_requant.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gelu_requant_if.sv
// gelu_requant_if
//   Bundles the stream signals of gelu_requant: the upstream GELU beat
//   (in_valid/qin), the static requant settings (qm/qshift), the flush
//   marker, the upstream enable, and the packed valid/ready output port.
//   Modports:
//     slave  - the gelu_requant block itself
//     master - whoever drives the stream and consumes the packed words
interface gelu_requant_if #(
  parameter int D_W  = 32,
  parameter int O_W  = 8,
  parameter int PACK = 4
);
  logic                  in_valid;
  logic signed [D_W-1:0] qin;
  logic signed [D_W-1:0] qm;
  logic [5:0]            qshift;
  logic                  flush;
  logic                  up_enable;
  logic                  m_valid;
  logic                  m_ready;
  logic [PACK*O_W-1:0]   m_data;
  logic [PACK-1:0]       m_keep;

  modport slave (
    input  in_valid, qin, qm, qshift, flush, m_ready,
    output up_enable, m_valid, m_data, m_keep
  );

  modport master (
    output in_valid, qin, qm, qshift, flush, m_ready,
    input  up_enable, m_valid, m_data, m_keep
  );
endinterface

// File: rtl/gelu_requant.sv
// gelu_requant
//   Stream sink for the integer GELU pipeline. Each accepted 32-bit beat is
//   requantized (multiply by qm, optional round, arithmetic shift by qshift),
//   saturated to signed O_W bits and packed PACK lanes per word. Words go
//   through a first-word-fall-through FIFO to a valid/ready master port.
//   up_enable freezes the upstream pipeline when the FIFO nears full.
//
//   Configuration macro: GELU_REQUANT_ROUND_EN
//     defined   - round-half-up (adds 1 << (qshift-1) before the shift)
//     undefined - plain truncating arithmetic shift (default build)
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     bus  - gelu_requant_if.slave:
//            in_valid/qin   upstream beat (held while up_enable is low)
//            qm/qshift      static requant multiplier / shift
//            flush          one-cycle pulse, emits the pending partial word
//            up_enable      drives upstream enable
//            m_valid/m_ready/m_data/m_keep  packed output words
module gelu_requant #(
  parameter int D_W        = 32,
  parameter int O_W        = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  gelu_requant_if.slave  bus
);

  localparam int P_W    = 2 * D_W;
  localparam int W_W    = PACK * O_W;
  localparam int E_W    = W_W + PACK;
  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_HI    = CNT_W'(FIFO_DEPTH - 2);

  // Clamp a full-width requant result into the signed O_W lane range.
  function automatic logic [O_W-1:0] sat_fn(input logic signed [P_W-1:0] x);
    logic signed [P_W-1:0] hi;
    logic signed [P_W-1:0] lo;
    hi = {{(P_W-O_W+1){1'b0}}, {(O_W-1){1'b1}}};
    lo = {{(P_W-O_W+1){1'b1}}, {(O_W-1){1'b0}}};
    if (x > hi) begin
      return hi[O_W-1:0];
    end else if (x < lo) begin
      return lo[O_W-1:0];
    end else begin
      return x[O_W-1:0];
    end
  endfunction

  // Circular pointer increment that also works for non power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // ---------------------------------------------------------------------
  // Beat qualification and stage 1 (full-width product)
  // ---------------------------------------------------------------------
  logic                  up_enable_r;
  logic                  en_q_r;
  logic                  accept_s;
  logic signed [P_W-1:0] qin_x_s;
  logic signed [P_W-1:0] qm_x_s;
  logic signed [P_W-1:0] prod_s;
  logic                  v1_r;
  logic                  f1_r;
  logic signed [P_W-1:0] p1_r;

  // A held upstream beat is only new if enable was high on the edge that
  // produced it, which is exactly what the delayed enable en_q_r tells us.
  always_comb begin
    accept_s = bus.in_valid && en_q_r;
    qin_x_s  = {{D_W{bus.qin[D_W-1]}}, bus.qin};
    qm_x_s   = {{D_W{bus.qm[D_W-1]}}, bus.qm};
    prod_s   = qin_x_s * qm_x_s;
  end

  // Stage 1 register: product with its valid and flush markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0;
      f1_r <= 1'b0;
      p1_r <= {P_W{1'b0}};
    end else begin
      v1_r <= accept_s;
      f1_r <= bus.flush;
      p1_r <= prod_s;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: optional rounding and arithmetic shift
  // ---------------------------------------------------------------------
  logic signed [P_W-1:0] shr_s;
  logic                  v2_r;
  logic                  f2_r;
  logic signed [P_W-1:0] r2_r;

`ifdef GELU_REQUANT_ROUND_EN
  logic signed [P_W-1:0] rnd_s;
  logic signed [P_W-1:0] sum_s;

  // Round half up: add half an LSB of the shifted result before shifting.
  always_comb begin
    if (bus.qshift != 6'd0) begin
      rnd_s = {{(P_W-1){1'b0}}, 1'b1} << (bus.qshift - 6'd1);
    end else begin
      rnd_s = {P_W{1'b0}};
    end
    sum_s = p1_r + rnd_s;
    shr_s = sum_s >>> bus.qshift;
  end
`else
  // Truncating shift: floor division by 2^qshift.
  always_comb begin
    shr_s = p1_r >>> bus.qshift;
  end
`endif

  // Stage 2 register: shifted result with markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r <= 1'b0;
      f2_r <= 1'b0;
      r2_r <= {P_W{1'b0}};
    end else begin
      v2_r <= v1_r;
      f2_r <= f1_r;
      r2_r <= shr_s;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 3: saturation
  // ---------------------------------------------------------------------
  logic           v3_r;
  logic           f3_r;
  logic [O_W-1:0] s3_r;

  // Stage 3 register: saturated lane value with markers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_r <= 1'b0;
      f3_r <= 1'b0;
      s3_r <= {O_W{1'b0}};
    end else begin
      v3_r <= v2_r;
      f3_r <= f2_r;
      s3_r <= sat_fn(r2_r);
    end
  end

  // ---------------------------------------------------------------------
  // Packer
  // ---------------------------------------------------------------------
  logic [LANE_W-1:0] lane_r;
  logic [W_W-1:0]    acc_r;
  logic              push_r;
  logic [W_W-1:0]    push_data_r;
  logic [PACK-1:0]   push_keep_r;

  logic [W_W-1:0]    acc_s;
  logic [LANE_W:0]   filled_s;
  logic [LANE_W-1:0] lane_nxt_s;
  logic [W_W-1:0]    acc_nxt_s;
  logic              push_s;
  logic [PACK-1:0]   keep_s;

  // The beat is placed first, then the flush marker is judged against the
  // updated lane count; a beat that completes the word makes the flush a
  // no-op because nothing is left pending. acc_r is cleared on every push,
  // so unused lanes of a partial word are already zero.
  always_comb begin
    acc_s = acc_r;
    if (v3_r) begin
      acc_s[lane_r*O_W +: O_W] = s3_r;
      filled_s = {1'b0, lane_r} + {{LANE_W{1'b0}}, 1'b1};
    end else begin
      filled_s = {1'b0, lane_r};
    end

    if (v3_r && (lane_r == LANE_LAST)) begin
      push_s     = 1'b1;
      keep_s     = {PACK{1'b1}};
      lane_nxt_s = {LANE_W{1'b0}};
      acc_nxt_s  = {W_W{1'b0}};
    end else if (f3_r && (filled_s != {(LANE_W+1){1'b0}})) begin
      push_s     = 1'b1;
      keep_s     = ~({PACK{1'b1}} << filled_s);
      lane_nxt_s = {LANE_W{1'b0}};
      acc_nxt_s  = {W_W{1'b0}};
    end else begin
      push_s     = 1'b0;
      keep_s     = {PACK{1'b0}};
      lane_nxt_s = filled_s[LANE_W-1:0];
      acc_nxt_s  = acc_s;
    end
  end

  // Packer state and the registered push toward the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_r      <= {LANE_W{1'b0}};
      acc_r       <= {W_W{1'b0}};
      push_r      <= 1'b0;
      push_data_r <= {W_W{1'b0}};
      push_keep_r <= {PACK{1'b0}};
    end else begin
      lane_r      <= lane_nxt_s;
      acc_r       <= acc_nxt_s;
      push_r      <= push_s;
      push_data_r <= acc_s;
      push_keep_r <= keep_s;
    end
  end

  // ---------------------------------------------------------------------
  // Output FIFO with a registered head (first-word-fall-through timing)
  // ---------------------------------------------------------------------
  logic [E_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             m_valid_r;
  logic [W_W-1:0]   m_data_r;
  logic [PACK-1:0]  m_keep_r;

  logic             full_s;
  logic             pop_s;
  logic             wr_en_s;
  logic [CNT_W-1:0] remain_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [E_W-1:0]   head_nxt_s;

  // The head register is loaded with what will be at the read pointer after
  // this edge: the word being pushed if the FIFO is otherwise empty, else the
  // stored entry. A push into a full FIFO is dropped rather than corrupting
  // the head; the checker reports it.
  always_comb begin
    full_s   = (count_r == CNT_FULL);
    pop_s    = m_valid_r && bus.m_ready;
    wr_en_s  = push_r && (!full_s || pop_s);
    remain_s = count_r - {{(CNT_W-1){1'b0}}, pop_s};
    count_nxt_s = remain_s + {{(CNT_W-1){1'b0}}, wr_en_s};
    if (pop_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (wr_en_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (count_nxt_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {E_W{1'b0}};
    end else if (remain_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {push_keep_r, push_data_r};
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage, pointers, output head and the enable chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {E_W{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      m_valid_r   <= 1'b0;
      m_data_r    <= {W_W{1'b0}};
      m_keep_r    <= {PACK{1'b0}};
      up_enable_r <= 1'b0;
      en_q_r      <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {push_keep_r, push_data_r};
      end
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      m_valid_r   <= (count_nxt_s != {CNT_W{1'b0}});
      m_keep_r    <= head_nxt_s[E_W-1:W_W];
      m_data_r    <= head_nxt_s[W_W-1:0];
      // Two free entries absorb the beats still in flight when enable drops.
      up_enable_r <= (count_r <= CNT_HI);
      en_q_r      <= up_enable_r;
    end
  end

  assign bus.up_enable = up_enable_r;
  assign bus.m_valid   = m_valid_r;
  assign bus.m_data    = m_data_r;
  assign bus.m_keep    = m_keep_r;

  gelu_requant_chk #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_r),
    .full  (full_s),
    .count (count_r)
  );

endmodule

// gelu_requant_chk
//   Property checker for the output FIFO of gelu_requant.
//   Ports: clk, rst, push (packer push), full (FIFO full), count (occupancy).
module gelu_requant_chk #(
  parameter int CNT_W      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  input logic             push,
  input logic             full,
  input logic [CNT_W-1:0] count
);

  no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

  count_in_range: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_gelu_requant.sv
module tb_gelu_requant;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  gelu_requant_if bus ();

  gelu_requant dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t       exp_q[$];
  logic [7:0]  pend[$];
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          qm_v = 1;
  int          qshift_v = 0;
  logic [31:0] last_data = 32'h0;
  logic [3:0]  last_keep = 4'h0;
  word_t       cmp_e;

  // Reference requant of one beat: exact product, optional half-up rounding,
  // floor shift, clamp to int8.
  function automatic logic [7:0] model_lane(input int x);
    longint p;
    longint r;
    p = longint'(x) * longint'(qm_v);
    if (qshift_v == 0) begin
      r = p;
    end else begin
`ifdef GELU_REQUANT_ROUND_EN
      r = (p + (64'sd1 <<< (qshift_v - 1))) >>> qshift_v;
`else
      r = p >>> qshift_v;
`endif
    end
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    return r[7:0];
  endfunction

  task automatic emit();
    word_t w;
    w.data = 32'h0;
    w.keep = 4'h0;
    for (int i = 0; i < pend.size(); i++) begin
      w.data[i*8 +: 8] = pend[i];
      w.keep[i] = 1'b1;
    end
    exp_q.push_back(w);
    pend.delete();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  // Behaves like the GELU output register: advances only on an edge where
  // enable was high, otherwise holds (or, with junk, wiggles qin).
  task automatic step(input bit hb, input int val, input bit fl, input bit junk);
    bit en_now;
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      en_now = bus.up_enable;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      if (en_now) break;
      if (junk) bus.qin = $urandom;
      guard++;
      if (guard > 400) begin
        checks++;
        errors++;
        $display("FAIL step_timeout: got up_enable low for %0d cycles, required high", guard);
        return;
      end
    end
    bus.in_valid = hb;
    if (hb) bus.qin = val;
    bus.flush = fl;
    if (hb) begin
      pend.push_back(model_lane(val));
      if (pend.size() == 4) emit();
    end
    if (fl && pend.size() > 0) emit();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    repeat (8) @(posedge clk);
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk({"drain_", name}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    chk({name, "_up_enable"}, {31'd0, bus.up_enable}, 32'd0);
    chk({name, "_m_valid"},   {31'd0, bus.m_valid},   32'd0);
    chk({name, "_m_data"},    bus.m_data,             32'd0);
    chk({name, "_m_keep"},    {28'd0, bus.m_keep},    32'd0);
  endtask

  task automatic set_requant(input int qm, input int qs);
    qm_v = qm;
    qshift_v = qs;
    bus.qm = qm;
    bus.qshift = 6'(qs);
  endtask

  // Every accepted word is compared against the model, in order.
  always @(negedge clk) begin
    if (!rst && bus.m_valid && bus.m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data=%08h keep=%h, required no word", bus.m_data, bus.m_keep);
      end else begin
        cmp_e = exp_q.pop_front();
        if (bus.m_data !== cmp_e.data || bus.m_keep !== cmp_e.keep) begin
          errors++;
          $display("FAIL word: got data=%08h keep=%h, required data=%08h keep=%h",
                   bus.m_data, bus.m_keep, cmp_e.data, cmp_e.keep);
        end
      end
      last_data = bus.m_data;
      last_keep = bus.m_keep;
      pops++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int p0;
    bus.in_valid = 1'b0;
    bus.qin = 32'sd0;
    bus.flush = 1'b0;
    bus.m_ready = 1'b1;
    set_requant(1, 0);

    // Reset values and up_enable rising one cycle after release
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("up_enable_before_rise", {31'd0, bus.up_enable}, 32'd0);
    @(negedge clk);
    chk("up_enable_rise", {31'd0, bus.up_enable}, 32'd1);

    // Saturation
    step(1, 5, 0, 0); step(1, -3, 0, 0); step(1, 200, 0, 0); step(1, -200, 0, 0);
    step(0, 0, 0, 0);
    wait_drain("sat");
    chk("sat_data", last_data, 32'h807FFD05);
    chk("sat_keep", {28'd0, last_keep}, 32'hF);

    // Rounding
    set_requant(3, 2);
    step(1, 1, 0, 0); step(1, -1, 0, 0); step(1, 2, 0, 0); step(1, -2, 0, 0);
    step(0, 0, 0, 0);
    wait_drain("round");
`ifdef GELU_REQUANT_ROUND_EN
    chk("round_data", last_data, 32'hFF02FF01);
`else
    chk("round_data", last_data, 32'hFE01FF00);
`endif

    // Flush of a partial word, empty flush, flush with the completing beat
    set_requant(1, 0);
    step(1, 10, 0, 0); step(1, 20, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    wait_drain("flush");
    chk("flush_data", last_data, 32'h0000140A);
    chk("flush_keep", {28'd0, last_keep}, 32'h3);
    p0 = pops;
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    wait_drain("flush_empty");
    chk("flush_empty_words", pops, p0);
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 1, 0);
    step(0, 0, 0, 0);
    wait_drain("flush_full");
    chk("flush_full_words", pops, p0 + 1);
    chk("flush_full_keep", {28'd0, last_keep}, 32'hF);
    chk("flush_full_data", last_data, 32'h04030201);

    // Backpressure with held beats and a changing stale qin
    p0 = pops;
    bus.m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) step(1, int'($urandom_range(0, 600)) - 300, 0, 1);
        step(0, 0, 0, 1);
      end
      begin
        repeat (80) @(posedge clk);
        @(negedge clk);
        chk("bp_up_enable_low", {31'd0, bus.up_enable}, 32'd0);
        chk("bp_m_valid", {31'd0, bus.m_valid}, 32'd1);
        @(posedge clk);
        #1 bus.m_ready = 1'b1;
      end
    join
    wait_drain("bp");
    chk("bp_words", pops, p0 + 10);

    // Reset mid-operation discards three pending lanes
    step(1, 7, 0, 0); step(1, 8, 0, 0); step(1, 9, 0, 0);
    step(0, 0, 0, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    pend.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("midrst");
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
    step(0, 0, 0, 0);
    wait_drain("midrst");
    chk("midrst_data", last_data, 32'h04030201);
    chk("midrst_keep", {28'd0, last_keep}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
